// File: rtl/shifter_arbiter.sv
// shifter_arbiter: one logical barrel shifter shared by NREQ requesters.
// A round-robin arbiter accepts one job at a time and returns the result
// on a single response channel tagged with the requester id.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester job handshake (ready is one-hot or zero)
//   req_data/amt/lr       packed job payloads, requester i at slice i
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_id      shifted result and the id of its owner
//   busy                  high while a job is in flight (SHIFT or RESP)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The block never needs valid held after acceptance. req_ready
// is a combinational function of req_valid; rsp_valid is held with stable
// rsp_data/rsp_id until rsp_ready.

module multi_barrel_shifter_mux #(
  parameter int N  = 10,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] amt,
  input  logic          lr,      // 0 = left, 1 = right
  output logic [N-1:0]  result
);
  // Stage k conditionally shifts by 2**k; zeros fill vacated bits.
  logic [AW:0][N-1:0] stage;

  assign stage[0] = data;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = !amt[k] ? stage[k] :
                        (lr ? (stage[k] >> SH) : (stage[k] << SH));
  end

  assign result = stage[AW];
endmodule

module shifter_arbiter #(
  parameter int N    = 10,
  parameter int NREQ = 4,
  parameter int AW   = $clog2(N),
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  input  logic [NREQ-1:0]    req_lr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_data,
  output logic [IW-1:0]      rsp_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  // state is left visible by name so checkers can bind to it.
  state_t state, state_next;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic [IW:0]   cand;

  logic [N-1:0]  sel_data;
  logic [AW-1:0] sel_amt;
  logic          sel_lr;

  logic [N-1:0]  op_data;
  logic [AW-1:0] op_amt;
  logic          op_lr;
  logic [IW-1:0] id_q;
  logic [N-1:0]  shift_out;

  // Round-robin search: walk downward from the farthest candidate so the
  // last hit (closest to rr_ptr, going upward with wrap) wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (req_valid[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  // Payload of the granted requester.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_lr   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == grant_idx) begin
        sel_data = req_data[k*N +: N];
        sel_amt  = req_amt[k*AW +: AW];
        sel_lr   = req_lr[k];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = SHIFT;
      SHIFT:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  multi_barrel_shifter_mux #(.N(N), .AW(AW)) u_shifter (
    .data   (op_data),
    .amt    (op_amt),
    .lr     (op_lr),
    .result (shift_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op_data  <= '0;
      op_amt   <= '0;
      op_lr    <= 1'b0;
      id_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_data <= sel_data;
            op_amt  <= sel_amt;
            op_lr   <= sel_lr;
            id_q    <= grant_idx;
            rr_ptr  <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        SHIFT: begin
          // Amounts of N or more shift every bit out.
          rsp_data <= ({1'b0, op_amt} >= (AW+1)'(N)) ? '0 : shift_out;
          rsp_id   <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;
  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int AW   = $clog2(N);
  localparam int IW   = $clog2(NREQ);
  localparam int EW   = IW + N;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*N-1:0]  req_data = '0;
  logic [NREQ*AW-1:0] req_amt = '0;
  logic [NREQ-1:0]    req_lr = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [N-1:0]       rsp_data;
  logic [IW-1:0]      rsp_id;
  logic               busy;

  shifter_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_lr(req_lr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int amt, input logic lr);
    longint v, p;
    if (amt >= N) return '0;
    v = longint'(d);
    p = longint'(1) << amt;
    if (lr) return N'(v / p);
    return N'((v * p) % (longint'(1) << N));
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (rr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  logic [EW-1:0] exp_q[$];

  // Cycle-level model: one job in flight, result visible two cycles after
  // acceptance, held until consumed, next arbitration the cycle after.
  bit m_idle    = 1'b1;
  int m_rr      = 0;
  int m_resp_at = 0;

  always @(negedge clk) begin
    int g;
    logic exp_rv;
    logic [NREQ-1:0] exp_rdy;
    logic [N-1:0] exp_d;
    if (reset) begin
      m_idle = 1'b1;
      m_rr   = 0;
      exp_q.delete();
    end else begin
      exp_rv = !m_idle && (cyc >= m_resp_at);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("busy", busy, !m_idle);
      g = pick(req_valid, m_rr);
      exp_rdy = '0;
      if (m_idle && g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (m_idle && g >= 0) begin
        exp_d = ref_shift(req_data[g*N +: N], int'(req_amt[g*AW +: AW]), req_lr[g]);
        exp_q.push_back({IW'(g), exp_d});
        m_rr      = (g + 1) % NREQ;
        m_idle    = 1'b0;
        m_resp_at = cyc + 2;
      end else if (exp_rv && rsp_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit           hold_prev = 1'b0;
  logic [N-1:0] prev_data;
  logic [IW-1:0] prev_id;
  logic [N-1:0] last_rsp_data = '0;
  logic [IW-1:0] last_rsp_id = '0;
  int           n_rsp = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_data", rsp_data, prev_data);
        chk("hold_id", rsp_id, prev_id);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e[EW-1:N]);
          chk("rsp_data", rsp_data, e[N-1:0]);
        end
        last_rsp_data = rsp_data;
        last_rsp_id   = rsp_id;
        n_rsp++;
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_id   = rsp_id;
    end
  end

  // Grant log (from observed req_ready) for order/spacing checks.
  int gl_id[$];
  int gl_cyc[$];
  logic [NREQ-1:0] ready_seen = '0;
  always @(negedge clk) begin
    ready_seen = req_ready;
    if (!reset && req_ready != '0) begin
      gl_id.push_back($clog2(req_ready));
      gl_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_job(input int i, input logic [N-1:0] d, input int a, input logic l);
    req_data[i*N +: N]  = d;
    req_amt[i*AW +: AW] = AW'(a);
    req_lr[i]           = l;
  endtask

  task automatic send(input int i, input logic [N-1:0] d, input int a, input logic l);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_job(i, d, a, l);
    req_valid[i] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk("send_accept", got, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    chk("idle_reached", done, 1'b1);
  endtask

  task automatic wait_grants(input int count, input int limit);
    for (int c = 0; c < limit && gl_id.size() < count; c++) @(negedge clk);
    chk("grant_count_reached", gl_id.size() >= count, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rsp_before;

    // Reset state, with every requester asserting valid.
    req_valid = '1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_req_ready", req_ready, '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_id", rsp_id, '0);
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Single left shift.
    send(0, 10'h003, 3, 1'b0);
    wait_idle(20);
    chk("left_data", last_rsp_data, 10'h018);
    chk("left_id", last_rsp_id, 0);

    // Right shift, then an out-of-range amount.
    send(2, 10'h200, 9, 1'b1);
    wait_idle(20);
    chk("right_data", last_rsp_data, 10'h001);
    chk("right_id", last_rsp_id, 2);
    send(2, 10'h3FF, 12, 1'b0);
    wait_idle(20);
    chk("over_data", last_rsp_data, 10'h000);

    // Move the pointer back to requester 0, then all four requesting.
    send(3, 10'h2A5, 1, 1'b1);
    wait_idle(20);
    gl_id.delete(); gl_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_job(i, N'(10'h011 * (i + 1)), i + 1, i[0]);
    req_valid = '1;
    wait_grants(6, 40);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);
    for (int k = 0; k < 6 && k < gl_id.size(); k++) begin
      chk("fair_order", gl_id[k], k % NREQ);
      if (k > 0) chk("fair_spacing", gl_cyc[k] - gl_cyc[k-1], 3);
    end

    // Backpressure with requesters 1 and 3 pending.
    gl_id.delete(); gl_cyc.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_job(1, 10'h0F0, 2, 1'b0);
    set_job(3, 10'h30C, 4, 1'b1);
    req_valid = 4'b1010;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = rsp_valid;
      end
      chk("bp_rsp_seen", seen, 1'b1);
    end
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grants(2, 20);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);
    if (gl_id.size() >= 2) begin
      chk("bp_first_grant", gl_id[0], 3);
      chk("bp_next_grant", gl_id[1], 1);
    end

    // Reset during SHIFT with requester 0 waiting.
    rsp_before = n_rsp;
    @(posedge clk); #1;
    set_job(1, 10'h0AA, 1, 1'b0);
    req_valid = 4'b0010;
    for (int c = 0; c < 20 && !req_ready[1]; c++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    set_job(0, 10'h155, 2, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_req_ready", req_ready, '0);
    @(posedge clk); #1;
    gl_id.delete(); gl_cyc.delete();
    reset = 1'b0;
    wait_grants(1, 20);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);
    if (gl_id.size() >= 1) chk("postreset_grant", gl_id[0], 0);
    chk("postreset_rsp_count", n_rsp - rsp_before, 1);
    chk("postreset_data", last_rsp_data, 10'h055);
    chk("postreset_id", last_rsp_id, 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || ready_seen[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_job(i, N'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(40);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one multi_barrel_shifter_mux (left/right logical shifter, width N) among NREQ requesters.
- Requesters present {data, amt, lr} jobs on a valid/ready handshake. A round-robin grant selects one job, the job is shifted, and the result is returned on a single valid/ready response channel tagged with the requester id.
- Sits between the requesting datapath blocks and the shared shifter instance. Only one job is in flight at a time.

Parameters:
- N, 10, shifter data width in bits.
- NREQ, 4, number of requesters (>= 2).
- AW, $clog2(N), shift-amount width (derived; do not override).
- IW, $clog2(NREQ), requester id width (derived; do not override).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has a job.
- req_ready  output  NREQ  bit i: job i accepted this cycle (one-hot or zero).
- req_data  input  NREQ*N  packed operands; requester i at [i*N +: N].
- req_amt  input  NREQ*AW  packed shift amounts; requester i at [i*AW +: AW].
- req_lr  input  NREQ  direction per requester: 0 = left, 1 = right.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  N  shifted result.
- rsp_id  output  IW  index of the requester that owns rsp_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 while reset is asserted.
  - Reset mid-job aborts the job silently; no response is ever produced for it.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready = one-hot grant, combinational from req_valid and rr_ptr.
  - The grant is the first asserted req_valid found searching from index rr_ptr upward, with wrap-around.
  - No valid requests: req_ready = 0, stay in IDLE.
  - When a grant exists (handshake completes the same cycle):
    - Capture data, amt and lr into operand registers and the grant index into the id register.
    - rr_ptr <= (grant index + 1) mod NREQ.
    - Go to SHIFT.
- SHIFT:
  - The shifter is driven from the operand registers.
  - If amt >= N, rsp_data <= 0; otherwise rsp_data <= shifter output.
  - Shifts are logical: zeros fill vacated bits.
  - rsp_id <= id register. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable until the handshake.
  - When rsp_ready = 1: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in the RESP cycle.
- req_ready is 0 in SHIFT and RESP regardless of req_valid.
- Latency and throughput:
  - Request accepted at cycle t; rsp_valid first high at t+2.
  - Best-case throughput is one job per 3 cycles.
- Handshake rules:
  - Requesters must hold valid and payload until ready. The block never depends on valid being held after acceptance.
  - Requester valid must not depend on req_ready; req_ready may depend on req_valid.
- rr_ptr changes only on a grant, so priority does not rotate while the bus is idle.
- Simultaneous events: requests arriving during SHIFT or RESP wait; they are arbitrated on the first IDLE cycle.
- rsp_valid is never asserted in IDLE or SHIFT.

Test Plan:
- Reset: assert reset mid-SHIFT with req0 pending -> same cycle rsp_valid=0, busy=0, req_ready=0000. After release, first grant goes to requester 0 (rr_ptr = 0); the aborted job produces no response.
- Single left shift: req0 data=10'h003, amt=3, lr=0, accepted at t, rsp_ready=1 -> rsp_valid at t+2 with rsp_data=10'h018, rsp_id=0, then IDLE at t+3.
- Right shift and overflow amount:
  - req2 data=10'h200, amt=9, lr=1 -> rsp_data=10'h001, rsp_id=2.
  - Then req2 data=10'h3FF, amt=12, lr=0 -> rsp_data=10'h000.
- Fairness: req_valid=1111 held continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, each grant spaced 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP with req_valid=1010 -> rsp_valid, rsp_data and rsp_id stable; req_ready=0000 throughout. After rsp_ready=1, the next grant goes to requester 1 or 3 according to rr_ptr.
